// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the single write port of sync_fifo.
// One requester owns the write port at a time and may write up to MAX_BURST
// words before ownership is released; a full FIFO stalls the owner in place.
//
// Handshake: req[i] is requester i's valid and req_ack[i] is the transfer
// strobe. A word moves in exactly the cycle where req_ack[i]=1, which only
// happens while i owns the port and fifo_full=0. The requester must hold
// req_data stable until that cycle and presents its next word on the
// following edge. owner_valid reports the FSM state (1 = OWN).
module fifo_write_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    input  logic                          fifo_full,
    output logic                          fifo_write,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          owner_valid,
    output logic [$clog2(NUM_REQ)-1:0]    owner_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] LAST_BEAT  = BCW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] LAST_INDEX = IDW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t         state, next_state;
    logic [IDW-1:0] owner, next_owner;
    logic [IDW-1:0] last_owner, next_last_owner;
    logic [BCW-1:0] burst_cnt, next_burst_cnt;

    logic [IDW-1:0] pick;
    logic [IDW-1:0] scan_idx;
    logic           found;
    logic           wr;

    // State register; reset drops any burst in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_INDEX;
            burst_cnt  <= '0;
        end else begin
            state      <= next_state;
            owner      <= next_owner;
            last_owner <= next_last_owner;
            burst_cnt  <= next_burst_cnt;
        end
    end

    // Round-robin search: first requester after last_owner, wrapping around.
    always_comb begin
        pick     = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IDW'((int'(last_owner) + k) % NUM_REQ);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    // Next-state logic and write-port outputs.
    always_comb begin
        next_state      = state;
        next_owner      = owner;
        next_last_owner = last_owner;
        next_burst_cnt  = burst_cnt;
        wr              = 1'b0;
        fifo_write      = 1'b0;
        req_ack         = '0;
        fifo_data_in    = '0;
        owner_valid     = 1'b0;
        owner_id        = '0;

        case (state)
            IDLE: begin
                if (found) begin
                    next_state     = OWN;
                    next_owner     = pick;
                    next_burst_cnt = '0;
                end
            end
            OWN: begin
                wr           = req[owner] & ~fifo_full;
                fifo_write   = wr;
                req_ack      = wr ? (NUM_REQ'(1) << owner) : '0;
                fifo_data_in = req_data[owner*FIFO_WIDTH +: FIFO_WIDTH];
                owner_valid  = 1'b1;
                owner_id     = owner;
                if (wr) begin
                    next_burst_cnt = burst_cnt + BCW'(1);
                end
                // A full FIFO only stalls; release needs a finished burst or a withdrawn req.
                if ((wr && (burst_cnt == LAST_BEAT)) || !req[owner]) begin
                    next_state      = IDLE;
                    next_last_owner = owner;
                    next_burst_cnt  = '0;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed vector bench for fifo_write_arbiter (FIFO_WIDTH=16, NUM_REQ=4,
// MAX_BURST=4). Requester i presents word {i, count_i}, where count_i
// advances after every expected ack for that requester.
module tb_fifo_write_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic           fifo_full;
  logic           fifo_write;
  logic [W-1:0]   fifo_data_in;
  logic           owner_valid;
  logic [1:0]     owner_id;

  fifo_write_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_BURST(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .fifo_full    (fifo_full),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .owner_valid  (owner_valid),
    .owner_id     (owner_id)
  );

  typedef struct {
    logic         rst_n;
    logic [N-1:0] req;
    logic         full;
    logic         wr;
    logic [N-1:0] ack;
    logic         ov;
    logic [1:0]   id;
    logic [W-1:0] data;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           word_cnt[N];
  int           n_vec;
  int           n_mis;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    req_data  = '0;
  end

  // table builders
  function automatic void v_rst(input logic [N-1:0] r);
    vecs.push_back('{1'b0, r, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000});
  endfunction

  function automatic void v_idle(input logic [N-1:0] r, input logic f);
    vecs.push_back('{1'b1, r, f, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000});
  endfunction

  function automatic void v_own(input logic [N-1:0] r, input logic f, input logic w,
                                input logic [1:0] id, input logic [W-1:0] d);
    logic [N-1:0] a;
    a = w ? (4'b0001 << id) : 4'b0000;
    vecs.push_back('{1'b1, r, f, w, a, 1'b1, id, d});
  endfunction

  // driver tasks
  task automatic drive_data();
    for (int i = 0; i < N; i++)
      req_data[i*W +: W] = {4'(i), 12'(word_cnt[i])};
  endtask

  task automatic check_vec(input int k, input vec_t v);
    n_vec++;
    if (fifo_write !== v.wr || req_ack !== v.ack || owner_valid !== v.ov ||
        owner_id !== v.id || fifo_data_in !== v.data) begin
      n_mis++;
      $display("FAIL vec%0d: got wr=%b ack=%b ov=%b id=%0d data=%h, need wr=%b ack=%b ov=%b id=%0d data=%h",
               k, fifo_write, req_ack, owner_valid, owner_id, fifo_data_in,
               v.wr, v.ack, v.ov, v.id, v.data);
    end
  endtask

  // scoreboard: expected FIFO writes queued, DUT writes popped and matched
  task automatic scoreboard(input int k, input vec_t v);
    if (v.wr) exp_q.push_back(v.data);
    if (fifo_write) begin
      if (fifo_full) begin
        n_mis++;
        $display("FAIL write_while_full vec%0d: got fifo_write=1, need 0", k);
      end
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL extra_write vec%0d: got data=%h, need no write", k, fifo_data_in);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (fifo_data_in !== e) begin
          n_mis++;
          $display("FAIL sb_data vec%0d: got %h, need %h", k, fifo_data_in, e);
        end
      end
    end
  endtask

  task automatic build_table();
    // reset dominates, then idle with no requests
    v_rst(4'b1111);
    v_idle(4'b0000, 1'b0);
    v_idle(4'b0000, 1'b0);
    v_idle(4'b0000, 1'b0);
    // single requester 2: burst of 4, one bubble, regrant, then withdraw
    v_idle(4'b0100, 1'b0);
    for (int i = 0; i < 4; i++) v_own(4'b0100, 1'b0, 1'b1, 2'd2, 16'h2000 + 16'(i));
    v_idle(4'b0100, 1'b0);
    v_own(4'b0100, 1'b0, 1'b1, 2'd2, 16'h2004);
    v_own(4'b0100, 1'b0, 1'b1, 2'd2, 16'h2005);
    v_own(4'b0000, 1'b0, 1'b0, 2'd2, 16'h2006);
    v_idle(4'b0000, 1'b0);
    // all requesting after reset: order 0,1,2,3,0; reset mid-burst of second grant
    v_rst(4'b1111);
    v_idle(4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) v_own(4'b1111, 1'b0, 1'b1, 2'd0, 16'h0000 + 16'(i));
    v_idle(4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) v_own(4'b1111, 1'b0, 1'b1, 2'd1, 16'h1000 + 16'(i));
    v_idle(4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) v_own(4'b1111, 1'b0, 1'b1, 2'd2, 16'h2006 + 16'(i));
    v_idle(4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) v_own(4'b1111, 1'b0, 1'b1, 2'd3, 16'h3000 + 16'(i));
    v_idle(4'b1111, 1'b0);
    v_own(4'b1111, 1'b0, 1'b1, 2'd0, 16'h0004);
    v_own(4'b1111, 1'b0, 1'b1, 2'd0, 16'h0005);
    v_rst(4'b1111);
    v_idle(4'b0000, 1'b0);
    v_idle(4'b0000, 1'b0);
    // owner 1 stalled by full for 3 cycles mid-burst
    v_idle(4'b0010, 1'b0);
    v_own(4'b0010, 1'b0, 1'b1, 2'd1, 16'h1004);
    v_own(4'b0010, 1'b0, 1'b1, 2'd1, 16'h1005);
    for (int i = 0; i < 3; i++) v_own(4'b0010, 1'b1, 1'b0, 2'd1, 16'h1006);
    v_own(4'b0010, 1'b0, 1'b1, 2'd1, 16'h1006);
    v_own(4'b0010, 1'b0, 1'b1, 2'd1, 16'h1007);
    v_idle(4'b0000, 1'b0);
    // owner 3 withdraws after one write; search from 0 picks 0 over 1
    v_idle(4'b1000, 1'b0);
    v_own(4'b1001, 1'b0, 1'b1, 2'd3, 16'h3004);
    v_own(4'b0011, 1'b0, 1'b0, 2'd3, 16'h3005);
    v_idle(4'b0011, 1'b0);
    v_own(4'b0011, 1'b0, 1'b1, 2'd0, 16'h0006);
    v_own(4'b0010, 1'b0, 1'b0, 2'd0, 16'h0007);
    v_idle(4'b0010, 1'b0);
    v_own(4'b0010, 1'b0, 1'b1, 2'd1, 16'h1008);
    v_own(4'b0000, 1'b0, 1'b0, 2'd1, 16'h1009);
    v_idle(4'b0000, 1'b0);
    // full held for a whole ownership period: no writes at all
    v_idle(4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) v_own(4'b0100, 1'b1, 1'b0, 2'd2, 16'h200A);
    v_own(4'b0000, 1'b1, 1'b0, 2'd2, 16'h200A);
    v_idle(4'b0000, 1'b1);
    v_idle(4'b0000, 1'b0);
  endtask

  // Hand-written: reset asserted between edges while a write is being offered.
  task automatic check_async_reset();
    vec_t v;
    @(negedge clk);
    reset_n   = 1'b1;
    req       = 4'b0001;
    fifo_full = 1'b0;
    drive_data();
    @(posedge clk);
    #2;
    v = '{1'b1, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0007};
    check_vec(1000, v);
    #1;
    reset_n = 1'b0;
    #1;
    v = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000};
    check_vec(1001, v);
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    for (int i = 0; i < N; i++) word_cnt[i] = 0;
    build_table();
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      if (k > 0) begin
        for (int i = 0; i < N; i++)
          if (vecs[k-1].ack[i]) word_cnt[i]++;
      end
      reset_n   = vecs[k].rst_n;
      req       = vecs[k].req;
      fifo_full = vecs[k].full;
      drive_data();
      #1;
      check_vec(k, vecs[k]);
      scoreboard(k, vecs[k]);
    end
    check_async_reset();
    // final report
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL sb_lost: got %0d words missing, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
